// File: rtl/aud_recorder_if.sv
// aud_recorder_if: codec serial inputs, control levels and the sample-memory write port.
// Write port: o_wen is a one-cycle strobe with no back-pressure; o_address/o_data are valid while o_wen=1.
interface aud_recorder_if #(
    parameter int ADDR_W = 20
);
    logic              i_lrc;
    logic              i_data;
    logic              i_start;
    logic              i_pause;
    logic              i_stop;
    logic [ADDR_W-1:0] o_address;
    logic [15:0]       o_data;
    logic              o_wen;
    logic              o_busy;
    logic              o_full;
    logic [2:0]        o_dbg_state;

    modport master (
        output i_lrc, i_data, i_start, i_pause, i_stop,
        input  o_address, o_data, o_wen, o_busy, o_full, o_dbg_state
    );

    modport slave (
        input  i_lrc, i_data, i_start, i_pause, i_stop,
        output o_address, o_data, o_wen, o_busy, o_full, o_dbg_state
    );
endinterface

// File: rtl/aud_recorder.sv
// aud_recorder: deserialises WM8731 I2S ADC words on AUD_BCLK and writes them to sample memory.
// Build option AUD_REC_STEREO_EN: also capture the right channel, interleaved L,R in memory.
module aud_recorder #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic          i_clk,
    input  logic          i_rst,
    aud_recorder_if.slave bus
);
`ifdef AUD_REC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SHIFT  = 3'd2,
        S_WRITE  = 3'd3,
        S_PAUSED = 3'd4
    } state_t;

    state_t            state_q;
    logic              lrc_q;
    logic              chan_q;   // 1 while the right word of an L,R pair is pending
    logic [3:0]        cnt_q;
    logic [15:0]       shift_q;
    logic [15:0]       shift_d;
    logic [15:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic              busy_q;
    logic              full_q;
    logic              pause_q;
    logic              frame_start;

    assign shift_d     = {shift_q[14:0], bus.i_data};
    assign frame_start = chan_q ? (!lrc_q && bus.i_lrc) : (lrc_q && !bus.i_lrc);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            lrc_q   <= 1'b1;
            chan_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            lrc_q <= bus.i_lrc;
            wen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        addr_q  <= '0;
                        full_q  <= 1'b0;
                        pause_q <= 1'b0;
                        chan_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.i_stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pause_q <= 1'b0;
                        chan_q  <= 1'b0;
                    end else if (bus.i_pause && !chan_q) begin
                        state_q <= S_PAUSED;
                        busy_q  <= 1'b0;
                    end else begin
                        // A pause between the L and R words waits for the pair to finish
                        if (bus.i_pause) pause_q <= 1'b1;
                        if (frame_start) begin
                            cnt_q   <= '0;
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bus.i_stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pause_q <= 1'b0;
                        chan_q  <= 1'b0;
                    end else begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 4'd1;
                        if (bus.i_pause) pause_q <= 1'b1;
                        if (cnt_q == 4'd15) begin
                            data_q  <= shift_d;
                            wen_q   <= 1'b1;
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // The strobe is on the bus during this state; commit the address now
                    if (addr_q == MAX_ADDR) begin
                        full_q  <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pause_q <= 1'b0;
                        chan_q  <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        if (bus.i_stop) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            pause_q <= 1'b0;
                            chan_q  <= 1'b0;
                        end else if (STEREO && !chan_q) begin
                            chan_q  <= 1'b1;
                            state_q <= S_WAIT;
                            if (bus.i_pause) pause_q <= 1'b1;
                        end else if (pause_q || bus.i_pause) begin
                            chan_q  <= 1'b0;
                            pause_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_PAUSED;
                        end else begin
                            chan_q  <= 1'b0;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_PAUSED: begin
                    if (bus.i_stop) begin
                        state_q <= S_IDLE;
                    end else if (!bus.i_pause && bus.i_start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_address   = addr_q;
    assign bus.o_data      = data_q;
    assign bus.o_wen       = wen_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_full      = full_q;
    assign bus.o_dbg_state = state_q;
endmodule

// File: tb/tb_aud_recorder.sv
// tb_aud_recorder: drives I2S frames into two recorders (full-size and MAX_ADDR=3) and
// checks every write against a session-level model of recording, pause, stop and full.
module tb_aud_recorder;
  localparam int AW = 20;
  localparam int EW = 32 + AW + 16;
  localparam int K_NONE = 0, K_PAUSE = 1, K_STOP = 2, K_RST = 3;
  localparam int M_IDLE = 0, M_REC = 1, M_PAUSED = 2;
`ifdef AUD_REC_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // expected write: {edge index where the strobe is visible, address, data}
  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  int m_state[2];
  logic [AW-1:0] m_addr[2];
  logic m_full[2];
  logic [AW-1:0] m_max[2];
  logic prev_wen[2];

  aud_recorder_if #(.ADDR_W(AW)) bus_a ();
  aud_recorder_if #(.ADDR_W(AW)) bus_b ();

  aud_recorder #(.ADDR_W(AW), .MAX_ADDR(20'hFFFFF)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
  aud_recorder #(.ADDR_W(AW), .MAX_ADDR(20'd3))     dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

  assign bus_b.i_lrc   = bus_a.i_lrc;
  assign bus_b.i_data  = bus_a.i_data;
  assign bus_b.i_start = bus_a.i_start;
  assign bus_b.i_pause = bus_a.i_pause;
  assign bus_b.i_stop  = bus_a.i_stop;

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push(input int d, input int at, input logic [AW-1:0] a, input logic [15:0] w);
    logic [EW-1:0] e;
    e = {32'(at), a, w};
    if (d == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
  endtask

  task automatic advance(input int d);
    if (m_addr[d] == m_max[d]) begin
      m_full[d] = 1'b1;
      m_state[d] = M_IDLE;
    end else begin
      m_addr[d] = m_addr[d] + 1'b1;
    end
  endtask

  task automatic model_frame(input int d, input int t, input int half, input logic [15:0] l,
                             input logic [15:0] r, input int kind, input bit rh);
    if (m_state[d] == M_REC) begin
      if (kind == K_NONE || kind == K_PAUSE || rh) begin
        push(d, t + 16, m_addr[d], l);
        advance(d);
        if (STEREO && !rh && m_state[d] == M_REC) begin
          push(d, t + half + 16, m_addr[d], r);
          advance(d);
        end
        if (kind == K_PAUSE && m_state[d] == M_REC) m_state[d] = M_PAUSED;
        if (kind == K_STOP) m_state[d] = M_IDLE;
      end else if (kind == K_STOP) begin
        m_state[d] = M_IDLE;
      end
    end else if (kind == K_STOP) begin
      m_state[d] = M_IDLE;
    end
    if (kind == K_RST) begin
      m_state[d] = M_IDLE;
      m_addr[d] = '0;
      m_full[d] = 1'b0;
    end
  endtask

  task automatic model_ctl(input bit st, input bit pa, input bit sp);
    for (int d = 0; d < 2; d++) begin
      if (m_state[d] == M_IDLE) begin
        if (st) begin
          m_state[d] = M_REC;
          m_addr[d] = '0;
          m_full[d] = 1'b0;
        end
      end else if (sp) begin
        m_state[d] = M_IDLE;
      end else if (pa) begin
        if (m_state[d] == M_REC) m_state[d] = M_PAUSED;
      end else if (st) begin
        m_state[d] = M_REC;
      end
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic mon(input int d, input logic wen, input logic [AW-1:0] a, input logic [15:0] w,
                     input logic busy);
    logic [EW-1:0] e;
    bit hit;
    string p;
    p = (d == 0) ? "a" : "b";
    hit = 1'b0;
    e = '0;
    if (d == 0) begin
      if (exp_a.size() > 0 && int'(exp_a[0][EW-1:AW+16]) <= cyc) begin
        e = exp_a.pop_front();
        hit = 1'b1;
      end
    end else begin
      if (exp_b.size() > 0 && int'(exp_b[0][EW-1:AW+16]) <= cyc) begin
        e = exp_b.pop_front();
        hit = 1'b1;
      end
    end
    if (hit) begin
      check({p, "_wen_at_t17"}, 64'(wen), 64'd1);
      check({p, "_wr_addr"}, 64'(a), 64'(e[AW+15:16]));
      check({p, "_wr_data"}, 64'(w), 64'(e[15:0]));
      check({p, "_busy_in_write"}, 64'(busy), 64'd1);
    end else if (wen) begin
      check({p, "_unexpected_wen"}, 64'(wen), 64'd0);
    end
    if (wen) check({p, "_wen_back_to_back"}, 64'(prev_wen[d]), 64'd0);
    prev_wen[d] = wen;
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.o_wen, bus_a.o_address, bus_a.o_data, bus_a.o_busy);
    mon(1, bus_b.o_wen, bus_b.o_address, bus_b.o_data, bus_b.o_busy);
  end

  task automatic check_ctl(input int d, input int kind, input logic [AW-1:0] a, input logic [15:0] w,
                           input logic wen, input logic busy, input logic full);
    string p;
    p = (d == 0) ? "a" : "b";
    if (kind == K_RST) begin
      check({p, "_rst_addr"}, 64'(a), 64'd0);
      check({p, "_rst_data"}, 64'(w), 64'd0);
      check({p, "_rst_wen"}, 64'(wen), 64'd0);
      check({p, "_rst_busy"}, 64'(busy), 64'd0);
      check({p, "_rst_full"}, 64'(full), 64'd0);
    end else begin
      check({p, "_stop_busy"}, 64'(busy), 64'd0);
      check({p, "_stop_addr"}, 64'(a), 64'(m_addr[d]));
      check({p, "_stop_wen"}, 64'(wen), 64'd0);
    end
  endtask

  task automatic post_ctl_check(input int kind);
    check_ctl(0, kind, bus_a.o_address, bus_a.o_data, bus_a.o_wen, bus_a.o_busy, bus_a.o_full);
    check_ctl(1, kind, bus_b.o_address, bus_b.o_data, bus_b.o_wen, bus_b.o_busy, bus_b.o_full);
  endtask

  task automatic idle_check();
    check("a_idle_addr", 64'(bus_a.o_address), 64'(m_addr[0]));
    check("a_idle_full", 64'(bus_a.o_full), 64'(m_full[0]));
    check("a_idle_busy", 64'(bus_a.o_busy), 64'(m_state[0] == M_REC));
    check("b_idle_addr", 64'(bus_b.o_address), 64'(m_addr[1]));
    check("b_idle_full", 64'(bus_b.o_full), 64'(m_full[1]));
    check("b_idle_busy", 64'(bus_b.o_busy), 64'(m_state[1] == M_REC));
  endtask

  // ---------------- drivers ----------------
  // kbit 0..15 selects a left-word bit, 16..31 a right-word bit, for the control pulse
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int half, input int kind,
                       input int kbit);
    int pos;
    int t;
    bit rh;
    rh = (kbit >= 16);
    pos = rh ? (half + 1 + (kbit - 16)) : (1 + kbit);
    for (int s = 0; s < 2 * half; s++) begin
      @(negedge clk);
      if (s == 0) begin
        t = cyc + 1;
        for (int d = 0; d < 2; d++) model_frame(d, t, half, l, r, kind, rh);
      end
      if (kind != K_NONE && kind != K_PAUSE && s == pos + 1) post_ctl_check(kind);
      bus_a.i_lrc = (s >= half);
      if (s >= 1 && s <= 16) bus_a.i_data = l[4'(16 - s)];
      else if (s >= half + 1 && s <= half + 16) bus_a.i_data = r[4'(half + 16 - s)];
      else bus_a.i_data = 1'($urandom_range(0, 1));
      bus_a.i_pause = (kind == K_PAUSE && s == pos);
      bus_a.i_stop  = (kind == K_STOP && s == pos);
      rst           = (kind == K_RST && s == pos);
    end
  endtask

  task automatic idle(input int n, input bit st, input bit pa, input bit sp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) idle_check();
      bus_a.i_lrc   = 1'b1;
      bus_a.i_data  = 1'($urandom_range(0, 1));
      bus_a.i_start = st && (i == 1);
      bus_a.i_pause = pa && (i == 1);
      bus_a.i_stop  = sp && (i == 1);
      if (i == 1) model_ctl(st, pa, sp);
    end
  endtask

  // ---------------- stimulus ----------------
  int op;
  int rk;
  int kind;
  int kbit;

  initial begin
    rst = 1'b1;
    bus_a.i_lrc = 1'b1;
    bus_a.i_data = 1'b0;
    bus_a.i_start = 1'b0;
    bus_a.i_pause = 1'b0;
    bus_a.i_stop = 1'b0;
    m_max[0] = 20'hFFFFF;
    m_max[1] = 20'd3;
    for (int d = 0; d < 2; d++) begin
      m_state[d] = M_IDLE;
      m_addr[d] = '0;
      m_full[d] = 1'b0;
      prev_wen[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    post_ctl_check(K_RST);

    // single frame, 32-BCLK halves
    idle(4, 1, 0, 0);
    frame(16'hA5C3, 16'h5A3C, 32, K_NONE, 0);
    idle(4, 0, 0, 0);

    // three back-to-back frames from address 0
    idle(4, 0, 0, 1);
    idle(4, 1, 0, 0);
    frame(16'h0001, 16'h1111, 32, K_NONE, 0);
    frame(16'h8000, 16'h2222, 32, K_NONE, 0);
    frame(16'hFFFF, 16'h3333, 32, K_NONE, 0);
    idle(4, 0, 0, 0);

    // pause at bit 8 of the second sample, resume later
    idle(4, 0, 0, 1);
    idle(4, 1, 0, 0);
    frame(16'h1357, 16'h2468, 32, K_NONE, 0);
    frame(16'hC0DE, 16'hBEEF, 32, K_PAUSE, 8);
    frame(16'hDEAD, 16'hF00D, 32, K_NONE, 0);
    idle(6, 1, 0, 0);
    frame(16'h7E57, 16'h0F0F, 32, K_NONE, 0);
    idle(4, 0, 0, 0);

    // stop at bit 5, then restart at 0
    frame(16'h4242, 16'h2424, 32, K_STOP, 5);
    idle(4, 0, 0, 0);
    idle(4, 1, 0, 0);

    // five frames: dut_b fills at address 3
    idle(4, 0, 0, 1);
    idle(4, 1, 0, 0);
    for (int i = 0; i < 5; i++) frame(16'($urandom), 16'($urandom), 32, K_NONE, 0);
    idle(4, 0, 0, 0);
    idle(4, 1, 0, 0);

    // L/R pair, then reset in the middle of the right word
    frame(16'h1234, 16'hABCD, 32, K_NONE, 0);
    frame(16'h1234, 16'hABCD, 32, K_RST, 16 + 7);
    idle(4, 1, 0, 0);
    frame(16'h0F1E, 16'h2D3C, 24, K_NONE, 0);

    // randomized sessions
    repeat (60) begin
      op = $urandom_range(0, 9);
      if (op < 7) begin
        rk = $urandom_range(0, 99);
        kind = K_NONE;
        kbit = 0;
        if (rk < 10) begin
          kind = K_PAUSE;
          kbit = $urandom_range(0, 15);
        end else if (rk < 18) begin
          kind = K_STOP;
          kbit = $urandom_range(0, 15);
        end else if (rk < 23) begin
          kind = K_STOP;
          kbit = $urandom_range(16, 31);
        end else if (rk < 27) begin
          kind = K_RST;
          kbit = $urandom_range(0, 31);
        end
        frame(16'($urandom), 16'($urandom), $urandom_range(18, 32), kind, kbit);
      end else begin
        idle($urandom_range(4, 8), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) == 0);
      end
    end

    idle(8, 0, 0, 1);
    check("a_writes_drained", 64'(exp_a.size()), 64'd0);
    check("b_writes_drained", 64'(exp_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
